// File: rtl/dram_cmd_ctrl_if.sv
// dram_cmd_ctrl_if: single-word request/response bus between the AXI bridge (master) and the DRAM command controller (slave)
interface dram_cmd_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [20:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_wstrb, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_wstrb, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dram_cmd_ctrl.sv
// dram_cmd_ctrl: turns single-word requests into PRE/ACT/RD/WR pin sequences with one tracked open row
// DRAM_CTRL_OPEN_PAGE_EN selects open-page policy; without it every access closes its row (closed-page).
module dram_cmd_ctrl #(
  parameter int T_RP  = 5,
  parameter int T_RCD = 5,
  parameter int T_WR  = 5,
  parameter int T_TO  = 63
) (
  input  logic           dram_clk,
  input  logic           dram_rst_n,
  dram_cmd_ctrl_if.slave bus,
  output logic           DRAM_CSn,
  output logic [3:0]     DRAM_WEn,
  output logic           DRAM_RASn,
  output logic           DRAM_CASn,
  output logic [10:0]    DRAM_A,
  output logic [31:0]    DRAM_D,
  input  logic [31:0]    DRAM_Q,
  input  logic           DRAM_VALID
);
  localparam int CW = $clog2(T_RP + T_RCD + T_WR + T_TO);
  typedef enum logic [2:0] {IDLE, PRE, ACT, RD, WR, RWAIT, WWAIT, RESP} state_t;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
  localparam state_t AFTER_PRE = ACT, AFTER_XFER = RESP;
`else
  localparam state_t AFTER_PRE = RESP, AFTER_XFER = PRE;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic ready_q, we_q, err_q, row_open, rsp_valid_q, rsp_err_q;
  logic [20:0] addr_q;
  logic [3:0] wstrb_q;
  logic [31:0] wdata_q, q_q, rsp_rdata_q;
  logic [10:0] open_row;
  logic acc, we_n, hit, cap, tmo, err_n, enter, pre_c, act_c, rd_c, wr_c;
  logic [20:0] addr_n;
  logic [3:0] wstrb_n;
  logic [31:0] wdata_n, q_n;
  // Request fields are used the same cycle they are accepted, so commands see the "_n" views
  always_comb begin
    acc = bus.req_valid & ready_q;
    we_n = acc ? bus.req_we : we_q;
    addr_n = acc ? bus.req_addr : addr_q;
    wstrb_n = acc ? bus.req_wstrb : wstrb_q;
    wdata_n = acc ? bus.req_wdata : wdata_q;
    hit = row_open && addr_n[20:10] == open_row;
    cap = state == RWAIT && DRAM_VALID;
    tmo = state == RWAIT && !DRAM_VALID && cnt == '0;
    err_n = acc ? 1'b0 : err_q | tmo;
    q_n = cap ? DRAM_Q : q_q;
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = hit ? (we_n ? WR : RD) : row_open ? PRE : ACT;
      PRE:     if (cnt == '0) nxt = AFTER_PRE;
      ACT:     if (cnt == '0) nxt = we_q ? WR : RD;
      RD:      nxt = RWAIT;
      WR:      nxt = WWAIT;
      RWAIT:   if (cap || tmo) nxt = AFTER_XFER;
      WWAIT:   if (cnt == '0) nxt = AFTER_XFER;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    enter = nxt != state;
    cnt_n = !enter ? (cnt == '0 ? '0 : cnt - 1'b1) :
            nxt == PRE   ? CW'(T_RP - 1)  :
            nxt == ACT   ? CW'(T_RCD - 1) :
            nxt == RWAIT ? CW'(T_TO - 1)  :
            nxt == WWAIT ? CW'(T_WR - 1)  : '0;
    pre_c = enter && nxt == PRE;
    act_c = enter && nxt == ACT;
    rd_c = enter && nxt == RD;
    wr_c = enter && nxt == WR;
  end
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      q_q <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      DRAM_CSn <= 1'b1;
      DRAM_RASn <= 1'b1;
      DRAM_CASn <= 1'b1;
      DRAM_WEn <= 4'hF;
      DRAM_A <= '0;
      DRAM_D <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      ready_q <= nxt == IDLE;
      we_q <= we_n;
      addr_q <= addr_n;
      wstrb_q <= wstrb_n;
      wdata_q <= wdata_n;
      err_q <= err_n;
      q_q <= q_n;
      row_open <= act_c ? 1'b1 : (pre_c || tmo) ? 1'b0 : row_open;
      open_row <= act_c ? addr_n[20:10] : open_row;
      DRAM_CSn <= nxt == IDLE;
      DRAM_RASn <= !(pre_c || act_c);
      DRAM_CASn <= !(rd_c || wr_c);
      DRAM_WEn <= pre_c ? 4'h0 : wr_c ? ~wstrb_n : 4'hF;
      DRAM_A <= act_c ? addr_n[20:10] : (rd_c || wr_c) ? {1'b0, addr_n[9:0]} : DRAM_A;
      DRAM_D <= wr_c ? wdata_n : DRAM_D;
      rsp_valid_q <= nxt == RESP;
      rsp_err_q <= nxt == RESP && err_n;
      rsp_rdata_q <= (nxt == RESP && !we_q && !err_n) ? q_n : rsp_rdata_q;
    end
  end
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dram_cmd_ctrl.sv
// tb_dram_cmd_ctrl: directed table plus random requests against a transaction-level timing model and a behavioural DRAM
module tb_dram_cmd_ctrl;
  localparam int T_RP = 5, T_RCD = 5, T_WR = 5, T_TO = 63;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif
  typedef struct {int c; int k; logic [10:0] a; logic [3:0] wen; logic [31:0] d; bit cd;} cmd_t;
  typedef struct {bit we; logic [20:0] addr; logic [3:0] wstrb; logic [31:0] wdata; int cl; logic [31:0] q; bit spur;
                  int lat_open; int lat_closed; bit err; logic [31:0] rdata;} vec_t;
  logic dram_clk = 1'b0, dram_rst_n = 1'b0;
  logic DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_VALID;
  logic [3:0] DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D, DRAM_Q;
  dram_cmd_ctrl_if bus();
  dram_cmd_ctrl dut (
    .dram_clk(dram_clk), .dram_rst_n(dram_rst_n), .bus(bus),
    .DRAM_CSn(DRAM_CSn), .DRAM_WEn(DRAM_WEn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_A(DRAM_A), .DRAM_D(DRAM_D), .DRAM_Q(DRAM_Q), .DRAM_VALID(DRAM_VALID)
  );
  always #5 dram_clk = ~dram_clk;
  int cyc = 0, checks = 0, failures = 0;
  always @(posedge dram_clk) cyc <= cyc + 1;
  cmd_t got[$];
  int rsp_n = 0, rsp_c = 0;
  logic rsp_e;
  logic [31:0] rsp_d;
  // Pin monitor: every non-NOP command and every response, stamped with the cycle number
  always @(negedge dram_clk) begin
    int k;
    if (dram_rst_n) begin
      k = (!DRAM_RASn && !DRAM_CASn) ? 7 : !DRAM_RASn ? (DRAM_WEn == 4'h0 ? 0 : 1) : 2;
      if (!DRAM_RASn || !DRAM_CASn) got.push_back('{cyc, k, DRAM_A, DRAM_WEn, DRAM_D, 1'b0});
      if (bus.rsp_valid) begin rsp_n++; rsp_c = cyc; rsp_e = bus.rsp_err; rsp_d = bus.rsp_rdata; end
    end
  end
  // Behavioural DRAM: VALID cl cycles after RD, junk VALIDs whenever no read data is owed
  bit rd_cfg = 0, spur_cfg = 0, quiet = 0;
  int cl_cfg = 0, vcyc = -1;
  logic [31:0] q_cfg = '0;
  always @(negedge dram_clk) begin
    DRAM_VALID = 1'b0;
    DRAM_Q = $urandom;
    if (!dram_rst_n) begin quiet = 0; vcyc = -1; end
    else begin
      if (bus.rsp_valid) quiet = 0;
      if (rd_cfg && !DRAM_CASn) begin quiet = 1; vcyc = cl_cfg > 0 ? cyc + cl_cfg : -1; DRAM_VALID = spur_cfg; end
      else if (cyc == vcyc) begin DRAM_VALID = 1'b1; DRAM_Q = q_cfg; vcyc = -1; end
      else if (!quiet) DRAM_VALID = $urandom_range(3) == 0;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin failures++; $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp); end
  endtask
  bit m_open = 0;
  logic [10:0] m_row = '0;
  logic [31:0] m_rdata = '0;
  task automatic idle_bus();
    bus.req_valid = 1'b0; bus.req_we = $urandom; bus.req_wstrb = $urandom; bus.req_addr = $urandom; bus.req_wdata = $urandom;
  endtask
  task automatic start_req(input bit we, input logic [20:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                           input int cl, input logic [31:0] q, input bit spur, output int a);
    int w = 0;
    rd_cfg = !we; cl_cfg = cl; q_cfg = q; spur_cfg = spur; rsp_n = 0;
    @(negedge dram_clk); #1;
    while (!bus.req_ready && w < 100) begin @(negedge dram_clk); #1; w++; end
    chk("ready_wait", w < 100, 1);
    a = cyc;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wstrb = wstrb; bus.req_wdata = wdata;
    @(negedge dram_clk); #1;
    idle_bus();
  endtask
  task automatic run_req(input bit we, input logic [20:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                         input int cl, input logic [31:0] q, input bit spur, output int lat);
    cmd_t exp[$];
    int a, t, w = 0, bad = 0;
    bit err = 0;
    chk("idle_cmds", got.size(), 0);
    got.delete();
    start_req(we, addr, wstrb, wdata, cl, q, spur, a);
    while (rsp_n == 0 && w < 200) begin
      @(negedge dram_clk); #1; w++;
      if (bus.req_ready || DRAM_CSn) bad++;
    end
    chk("rsp_arrived", w < 200, 1);
    t = a + 1;
    if (!(OPEN && m_open && m_row == addr[20:10])) begin
      if (m_open) begin exp.push_back('{t, 0, 11'h0, 4'h0, 32'h0, 1'b0}); t += T_RP; end
      exp.push_back('{t, 1, addr[20:10], 4'hF, 32'h0, 1'b0}); t += T_RCD;
      m_open = 1; m_row = addr[20:10];
    end
    exp.push_back('{t, 2, {1'b0, addr[9:0]}, we ? ~wstrb : 4'hF, wdata, we});
    if (we) t = t + 1 + T_WR;
    else if (cl >= 1 && cl <= T_TO) begin t = t + cl + 1; m_rdata = q; end
    else begin t = t + 1 + T_TO; err = 1; m_open = 0; end
    if (!OPEN) begin exp.push_back('{t, 0, 11'h0, 4'h0, 32'h0, 1'b0}); t += T_RP; m_open = 0; end
    chk("rsp_latency", rsp_c - a, t - a);
    chk("rsp_err", rsp_e, err);
    chk("rsp_rdata", rsp_d, m_rdata);
    chk("busy_pins", bad, 0);
    chk("cmd_count", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk("cmd_cycle", got[i].c - a, exp[i].c - a);
      chk("cmd_kind", got[i].k, exp[i].k);
      if (exp[i].k != 0) chk("cmd_a", got[i].a, exp[i].a);
      chk("cmd_wen", got[i].wen, exp[i].wen);
      if (exp[i].cd) chk("cmd_d", got[i].d, exp[i].d);
    end
    got.delete();
    lat = rsp_c - a;
  endtask
  task automatic chk_reset_pins();
    chk("rst_csn", DRAM_CSn, 1); chk("rst_rasn", DRAM_RASn, 1); chk("rst_casn", DRAM_CASn, 1);
    chk("rst_wen", DRAM_WEn, 4'hF); chk("rst_a", DRAM_A, 0); chk("rst_d", DRAM_D, 0);
    chk("rst_ready", bus.req_ready, 0); chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0); chk("rst_rdata", bus.rsp_rdata, 0);
  endtask
  vec_t vt[9];
  logic [10:0] rows[3];
  initial begin
    int lat, a, found, w;
    vt[0] = '{0, 21'h000400, 4'h0, 32'h0, 3, 32'hDEADBEEF, 1, 10, 15, 0, 32'hDEADBEEF};
    vt[1] = '{1, 21'h000401, 4'b0101, 32'h11223344, 0, 32'h0, 0, 7, 17, 0, 32'hDEADBEEF};
    vt[2] = '{0, 21'h000800, 4'h0, 32'h0, 2, 32'hCAFEF00D, 0, 14, 14, 0, 32'hCAFEF00D};
    vt[3] = '{0, 21'h000800, 4'h0, 32'h0, 0, 32'h0, 0, 65, 75, 1, 32'hCAFEF00D};
    vt[4] = '{0, 21'h000800, 4'h0, 32'h0, 1, 32'h12345678, 1, 8, 13, 0, 32'h12345678};
    vt[5] = '{1, 21'h1FFFFF, 4'h0, 32'hA5A5A5A5, 0, 32'h0, 0, 17, 17, 0, 32'h12345678};
    vt[6] = '{0, 21'h1FFFFF, 4'h0, 32'h0, T_TO, 32'h0F0F0F0F, 0, 65, 75, 0, 32'h0F0F0F0F};
    vt[7] = '{0, 21'h000400, 4'h0, 32'h0, 4, 32'h89ABCDEF, 1, 16, 16, 0, 32'h89ABCDEF};
    vt[8] = '{0, 21'h000400, 4'h0, 32'h0, 4, 32'h76543210, 0, 6, 16, 0, 32'h76543210};
    rows = '{11'h003, 11'h004, 11'h7FF};
    idle_bus();
    repeat (3) @(negedge dram_clk);
    #1 chk_reset_pins();
    dram_rst_n = 1'b1;
    foreach (vt[i]) begin
      run_req(vt[i].we, vt[i].addr, vt[i].wstrb, vt[i].wdata, vt[i].cl, vt[i].q, vt[i].spur, lat);
      chk("vec_latency", lat, OPEN ? vt[i].lat_open : vt[i].lat_closed);
      chk("vec_err", rsp_e, vt[i].err);
      chk("vec_rdata", rsp_d, vt[i].rdata);
    end
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 11);
      run_req($urandom_range(0, 1), {rows[$urandom_range(0, 2)], 10'($urandom)}, 4'($urandom), $urandom,
              r == 11 ? T_TO : r, $urandom, $urandom_range(0, 1), lat);
    end
    chk("pre_rst_idle_cmds", got.size(), 0);
    start_req(0, 21'h001400, 4'h0, 32'h0, 3, 32'h55AA55AA, 0, a);
    found = -1; w = 0;
    while (found < 0 && w < 30) begin
      @(negedge dram_clk); #1; w++;
      foreach (got[i]) if (got[i].k == 1) found = got[i].c;
    end
    chk("rst_act_seen", found >= 0, 1);
    while (cyc < found + 2 && w < 60) begin @(negedge dram_clk); #1; w++; end
    dram_rst_n = 1'b0;
    #1 chk_reset_pins();
    repeat (2) @(negedge dram_clk);
    dram_rst_n = 1'b1;
    m_open = 0; m_rdata = '0; got.delete(); rsp_n = 0;
    repeat (20) @(negedge dram_clk);
    #1 chk("rst_no_rsp", rsp_n, 0);
    run_req(0, 21'h001400, 4'h0, 32'h0, 2, 32'h600DF00D, 0, lat);
    chk("rst_reopen_latency", lat, OPEN ? T_RCD + 4 : T_RCD + 4 + T_RP);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end
endmodule
